// File: rtl/reg_file_pkg.sv
// Shared defaults and sizing helper for the parametrised register file.
// The default register count and width are 8 x 32.
package reg_file_pkg;

  localparam int RF_NUM_REGS = 8;
  localparam int RF_DATA_W   = 32;

  // Address width for n entries, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_register_file_mux.sv
// N-input, W-bit binary-select multiplexer built as a balanced tree of 2:1 stages.
// Inputs past N (up to the next power of two) read as zero.
module param_mux_n
  import reg_file_pkg::*;
#(
  parameter int N     = RF_NUM_REGS,
  parameter int W     = RF_DATA_W,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0][W-1:0] data,
  input  logic [SEL_W-1:0]    sel,
  output logic [W-1:0]        y
);

  localparam int P = 1 << SEL_W;

  // Heap-ordered tree: node 0 is the root, leaves occupy P-1 .. 2P-2.
  logic [W-1:0] node [0:2*P-2];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < N) begin : g_used
        assign node[P-1+gi] = data[gi];
      end else begin : g_pad
        assign node[P-1+gi] = '0;
      end
    end

    // A node at depth d steers on select bit SEL_W-1-d (MSB at the root).
    for (gi = 0; gi < P - 1; gi++) begin : g_stage
      localparam int D = $clog2(gi + 2) - 1;
      assign node[gi] = sel[SEL_W-1-D] ? node[2*gi+2] : node[2*gi+1];
    end
  endgenerate

  assign y = node[0];

endmodule

// File: rtl/param_register_file.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero register 0 and optional write-to-read bypass.
module param_register_file
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = clog2_min1(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             wen;
  logic                            write_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (ZERO_REG && gi == 0) begin : g_zero
        assign wen[gi]  = 1'b0;
        assign regs[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] q_reg;
        assign wen[gi] = we && (waddr == ADDR_W'(gi));
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= '0;
          end else if (wen[gi]) begin
            q_reg <= wdata;
          end
        end
        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  // Out-of-range and hardwired-zero addresses decode to no enable, so this
  // also tells the bypass whether the write will actually land.
  assign write_valid = |wen;

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] mux_out;
      logic              fwd;

      param_mux_n #(
        .N     (NUM_REGS),
        .W     (DATA_W),
        .SEL_W (ADDR_W)
      ) u_mux (
        .data (regs),
        .sel  (raddr[gi]),
        .y    (mux_out)
      );

      assign fwd = BYPASS && we && !reset && write_valid && (raddr[gi] == waddr);

      always_comb begin
        rdata[gi] = mux_out;
        if (ZERO_REG && raddr[gi] == '0) begin
          rdata[gi] = '0;
        end
        if (fwd) begin
          rdata[gi] = wdata;
        end
      end
    end
  endgenerate

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

endmodule
